// File: rtl/iiitb_lifo_if.sv
// Operation and status bundle for iiitb_lifo: the stack user drives the
// operation request and observes the popped word and the occupancy flags.
interface iiitb_lifo_if #(
  parameter int WIDTH = 4
);
  logic             EN;
  logic             RW;
  logic [WIDTH-1:0] dataIn;
  logic [WIDTH-1:0] dataOut;
  logic             EMPTY;
  logic             FULL;

  modport master (
    output EN, RW, dataIn,
    input  dataOut, EMPTY, FULL
  );

  modport slave (
    input  EN, RW, dataIn,
    output dataOut, EMPTY, FULL
  );
endinterface

// File: rtl/iiitb_lifo.sv
// DEPTH x WIDTH last-in-first-out stack with a registered pop output.
// Overflowing pushes and underflowing pops are ignored.
module iiitb_lifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input  logic       Clk,
  input  logic       Rst,
  iiitb_lifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      sp_r;
  logic [WIDTH-1:0] dataout_r;

  logic             empty_s;
  logic             full_s;
  logic             push_s;
  logic             pop_s;
  logic [AW:0]      sp_dec_s;
  logic [AW-1:0]    wr_idx_s;
  logic [AW-1:0]    rd_idx_s;

  // Flags and operation qualifiers derive from the registered pointer only.
  always_comb begin
    empty_s  = (sp_r == '0);
    full_s   = (sp_r == FULL_CNT);
    push_s   = bus.EN & ~bus.RW & ~full_s;
    pop_s    = bus.EN &  bus.RW & ~empty_s;
    sp_dec_s = sp_r - {{AW{1'b0}}, 1'b1};
    wr_idx_s = sp_r[AW-1:0];
    rd_idx_s = sp_dec_s[AW-1:0];
  end

  // Stack pointer and popped-word register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      sp_r      <= '0;
      dataout_r <= '0;
    end else if (push_s) begin
      sp_r      <= sp_r + {{AW{1'b0}}, 1'b1};
      dataout_r <= dataout_r;
    end else if (pop_s) begin
      sp_r      <= sp_dec_s;
      dataout_r <= mem_r[rd_idx_s];
    end else begin
      sp_r      <= sp_r;
      dataout_r <= dataout_r;
    end
  end

  // Storage array; popped entries are kept until a later push overwrites them.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push_s) begin
      mem_r[wr_idx_s] <= bus.dataIn;
    end else begin
      mem_r <= mem_r;
    end
  end

  assign bus.dataOut = dataout_r;
  assign bus.EMPTY   = empty_s;
  assign bus.FULL    = full_s;
endmodule

// File: tb/tb_iiitb_lifo.sv
// Directed self-checking bench for iiitb_lifo (WIDTH=4, DEPTH=8).
module tb_iiitb_lifo;
  logic Clk;
  logic Rst;
  int   total;
  int   bad;

  iiitb_lifo_if #(.WIDTH(4)) bus ();

  iiitb_lifo #(.WIDTH(4), .DEPTH(8)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // One clock cycle with the given request; returns at the following negedge.
  task automatic op(input logic en, input logic rw, input logic [3:0] din);
    bus.EN     = en;
    bus.RW     = rw;
    bus.dataIn = din;
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic push(input logic [3:0] din);
    op(1'b1, 1'b0, din);
  endtask

  task automatic pop_chk(input string tag, input logic [3:0] exp);
    op(1'b1, 1'b1, 4'h0);
    check(tag, {4'h0, bus.dataOut}, {4'h0, exp});
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset();
    bus.EN = 1'b0;
    #2 Rst = 1'b0;
    #1;
    check("rst_empty", {7'h0, bus.EMPTY}, 8'h01);
    check("rst_dout", {4'h0, bus.dataOut}, 8'h00);
    @(negedge Clk);
    Rst = 1'b1;
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    Rst        = 1'b0;
    bus.EN     = 1'b0;
    bus.RW     = 1'b0;
    bus.dataIn = 4'h0;

    // Power-up reset held for 5 cycles
    repeat (5) @(negedge Clk);
    check("pwr_dout", {4'h0, bus.dataOut}, 8'h00);
    check("pwr_empty", {7'h0, bus.EMPTY}, 8'h01);
    check("pwr_full", {7'h0, bus.FULL}, 8'h00);
    Rst = 1'b1;

    // LIFO order and underflow
    push(4'h0);
    check("p1_empty", {7'h0, bus.EMPTY}, 8'h00);
    push(4'h2);
    push(4'h4);
    push(4'h6);
    pop_chk("ord_1", 4'h6);
    pop_chk("ord_2", 4'h4);
    pop_chk("ord_3", 4'h2);
    check("ord_ne", {7'h0, bus.EMPTY}, 8'h00);
    pop_chk("ord_4", 4'h0);
    check("ord_empty", {7'h0, bus.EMPTY}, 8'h01);
    pop_chk("underflow", 4'h0);
    check("uf_empty", {7'h0, bus.EMPTY}, 8'h01);

    // Fill, overflow, drain
    for (int i = 1; i <= 8; i++) begin
      check("fill_notfull", {7'h0, bus.FULL}, 8'h00);
      push(4'(i));
    end
    check("full_set", {7'h0, bus.FULL}, 8'h01);
    push(4'hF);
    check("ovf_full", {7'h0, bus.FULL}, 8'h01);
    check("ovf_dout", {4'h0, bus.dataOut}, 8'h00);
    pop_chk("ovf_pop8", 4'h8);
    check("ovf_nfull", {7'h0, bus.FULL}, 8'h00);
    for (int i = 7; i >= 1; i--) begin
      pop_chk("drain", 4'(i));
    end
    check("drain_empty", {7'h0, bus.EMPTY}, 8'h01);

    // Enable gating with 3 words stored
    push(4'h3);
    push(4'h5);
    push(4'h9);
    for (int i = 0; i < 4; i++) begin
      op(1'b0, i[0], 4'(4'hC + i));
      check("en0_dout", {4'h0, bus.dataOut}, 8'h01);
      check("en0_empty", {7'h0, bus.EMPTY}, 8'h00);
      check("en0_full", {7'h0, bus.FULL}, 8'h00);
    end
    pop_chk("en0_pop", 4'h9);
    pop_chk("en0_pop2", 4'h5);

    // Async reset mid-operation with 5 words stored
    async_reset();
    for (int i = 0; i < 5; i++) begin
      push(4'(4'hA + i));
    end
    pop_chk("pre_rst_pop", 4'hE);
    async_reset();
    pop_chk("post_rst_pop", 4'h0);
    check("post_rst_empty", {7'h0, bus.EMPTY}, 8'h01);

    // Reset overrides an enabled push across a clock edge
    bus.EN = 1'b1;
    bus.RW = 1'b0;
    bus.dataIn = 4'h7;
    Rst = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
    bus.EN = 1'b0;
    check("rst_ovr_empty", {7'h0, bus.EMPTY}, 8'h01);

    // Refill after pops
    push(4'hA);
    push(4'hB);
    pop_chk("refill_b", 4'hB);
    push(4'hC);
    pop_chk("refill_c", 4'hC);
    pop_chk("refill_a", 4'hA);
    check("refill_empty", {7'h0, bus.EMPTY}, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
